// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a 16x4 synchronous RAM.
// Also runs a clear sweep that zeroes every RAM word.
module ram_arbiter (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [3:0] wdata0,
  input  logic [3:0] wdata1,
  input  logic       clr_start,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [3:0] rdata,
  output logic       busy,
  output logic       ram_we,
  output logic       ram_re,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_din,
  input  logic [3:0] ram_dout
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       we_q, we_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] din_q, din_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 4'd0;
      din_q   <= 4'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    // read data returns one cycle after the grant, whatever the state
    rv0_d   = gnt0_q & ~we_q;
    rv1_d   = gnt1_q & ~we_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = 4'd0;
        end else if (req0 && (!req1 || last_q)) begin
          gnt0_d = 1'b1;
          last_d = 1'b0;
          we_d   = we0;
          addr_d = addr0;
          din_d  = wdata0;
        end else if (req1) begin
          gnt1_d = 1'b1;
          last_d = 1'b1;
          we_d   = we1;
          addr_d = addr1;
          din_d  = wdata1;
        end
      end
      CLEAR: begin
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic clr;
  logic gnt_any;

  assign clr      = (state_q == CLEAR);
  assign gnt_any  = gnt0_q | gnt1_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rv0_q;
  assign rvalid1  = rv1_q;
  assign rdata    = (rv0_q | rv1_q) ? ram_dout : 4'd0;
  assign busy     = clr;
  assign ram_we   = clr | (gnt_any & we_q);
  assign ram_re   = ~clr & gnt_any & ~we_q;
  assign ram_addr = clr ? cnt_q : (gnt_any ? addr_q : 4'd0);
  assign ram_din  = (!clr && gnt_any) ? din_q : 4'd0;

endmodule
